// File: rtl/mem_ctrl.sv
// Data-memory controller between the MEM stage, a UART loader and a single-port BRAM.
// Stores complete in one cycle; loads stall for the BRAM latency and are extended on return.
module mem_ctrl #(
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          core_addr,
  input  logic [31:0]          core_wdata,
  input  logic                 core_we,
  input  logic                 core_re,
  input  logic [2:0]           core_ldst,
  output logic [31:0]          core_rdata,
  output logic                 core_stall,
  output logic                 core_misalign,
  input  logic                 uart_mode,
  input  logic                 uart_we,
  input  logic [ADDR_BITS-1:0] uart_addr,
  input  logic [31:0]          uart_wdata,
  output logic [ADDR_BITS-1:0] bram_addr,
  output logic [31:0]          bram_wdata,
  output logic [3:0]           bram_be,
  input  logic [31:0]          bram_rdata
);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdDone, StLoad} state_t;

  localparam logic [1:0] LastCnt = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;

  logic [1:0]  off;
  logic        legal_code;
  logic        misaligned;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        unused_addr_hi;

  assign off            = core_addr[1:0];
  assign unused_addr_hi = ^core_addr[31:ADDR_BITS+2];

  always_comb begin
    legal_code = 1'b0;
    case (core_ldst)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_code = 1'b1;
      default:                                legal_code = 1'b0;
    endcase
  end

  assign misaligned = !legal_code
                    || (core_ldst[1:0] == 2'b01 && off[0])
                    || (core_ldst[1:0] == 2'b10 && off != 2'b00);

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = core_wdata;
    case (core_ldst[1:0])
      2'b00: begin
        store_be    = 4'b0001 << off;
        store_wdata = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << off;
        store_wdata = {2{core_wdata[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = core_wdata;
      end
    endcase
  end

  // Halfword loads are aligned here, so off is 0 or 2 and the shift lands the half at [15:0].
  assign shifted = bram_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = bram_rdata;
    case (core_ldst[1:0])
      2'b00:   load_ext = core_ldst[2] ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = core_ldst[2] ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = bram_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    core_stall    = 1'b0;
    core_misalign = 1'b0;
    core_rdata    = rdata_q;
    bram_addr     = core_addr[ADDR_BITS+1:2];
    bram_wdata    = store_wdata;
    bram_be       = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (uart_mode) begin
          state_d    = StLoad;
          core_stall = core_we | core_re;
        end else if (core_we) begin
          if (misaligned) begin
            core_misalign = 1'b1;
            core_rdata    = '0;
          end else begin
            bram_be = store_be;
          end
        end else if (core_re) begin
          if (misaligned) begin
            core_misalign = 1'b1;
            core_rdata    = '0;
          end else begin
            core_stall = 1'b1;
            state_d    = StRdWait;
            cnt_d      = '0;
          end
        end
      end
      StRdWait: begin
        core_stall = 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StRdDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StRdDone: begin
        core_rdata = load_ext;
        // A loader request that arrived mid-read is honoured only after the read returns.
        state_d    = uart_mode ? StLoad : StIdle;
      end
      StLoad: begin
        core_stall = core_we | core_re;
        bram_addr  = uart_addr;
        bram_wdata = uart_wdata;
        bram_be    = {4{uart_we}};
        if (!uart_mode) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      state_d       = StIdle;
      cnt_d         = '0;
      core_misalign = 1'b0;
      core_rdata    = '0;
      bram_be       = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= core_rdata;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural BRAM with configurable latency plus a word-array reference model.
// Directed scenarios are followed by randomized loads/stores checked against the model.
module tb_mem_ctrl;

  localparam int unsigned AB     = 10;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 1 << AB;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   core_addr, core_wdata, core_rdata;
  logic          core_we, core_re, core_stall, core_misalign;
  logic [2:0]    core_ldst;
  logic          uart_mode, uart_we;
  logic [AB-1:0] uart_addr, bram_addr;
  logic [31:0]   uart_wdata, bram_wdata, bram_rdata;
  logic [3:0]    bram_be;

  int checks   = 0;
  int failures = 0;

  logic          mem_init;
  logic [31:0]   bram_mem [DEPTH];
  logic [31:0]   rd_pipe  [RD_LAT];
  logic [31:0]   ref_mem  [DEPTH];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_BITS(AB), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_we       (core_we),
    .core_re       (core_re),
    .core_ldst     (core_ldst),
    .core_rdata    (core_rdata),
    .core_stall    (core_stall),
    .core_misalign (core_misalign),
    .uart_mode     (uart_mode),
    .uart_we       (uart_we),
    .uart_addr     (uart_addr),
    .uart_wdata    (uart_wdata),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata),
    .bram_be       (bram_be),
    .bram_rdata    (bram_rdata)
  );

  // Byte-enabled BRAM; read data appears RD_LAT cycles after the address.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) bram_mem[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (bram_be[i]) bram_mem[bram_addr][8*i +: 8] <= bram_wdata[8*i +: 8];
    end
    rd_pipe[0] <= bram_mem[bram_addr];
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic ref_bad(input logic [31:0] a, input logic [2:0] c);
    if (!(c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (c == 3'd1 || c == 3'd5) return (a % 2) != 0;
    if (c == 3'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int unsigned ref_idx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] c);
    case (c % 4)
      0:       return 4'(1 << (a % 4));
      1:       return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] c);
    case (c % 4)
      0:       return (d & 32'hFF) * 32'h0101_0101;
      1:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [31:0] d,
                                    input logic [2:0] c);
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] mask;
    be   = ref_be(a, c);
    wd   = ref_wdata(d, c);
    mask = 0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    ref_mem[ref_idx(a)] = (ref_mem[ref_idx(a)] & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] w, v;
    int unsigned sh;
    w  = ref_mem[ref_idx(a)];
    sh = 8 * (a % 4);
    v  = w;
    case (c)
      3'd0: begin v = (w >> sh) & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd4: v = (w >> sh) & 32'hFF;
      3'd1: begin v = (w >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd5: v = (w >> sh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    logic bad;
    @(negedge clk);
    core_addr  = a;
    core_wdata = d;
    core_ldst  = c;
    core_we    = 1'b1;
    core_re    = 1'($urandom_range(0, 1));
    #1;
    bad = ref_bad(a, c);
    check1("st_stall", core_stall, 1'b0);
    check1("st_misalign", core_misalign, bad);
    check("st_be", 32'(bram_be), bad ? 32'h0 : 32'(ref_be(a, c)));
    if (bad) begin
      check("st_bad_rdata", core_rdata, 32'h0);
    end else begin
      check("st_wdata", bram_wdata, ref_wdata(d, c));
      check("st_addr", 32'(bram_addr), 32'(ref_idx(a)));
      ref_store(a, d, c);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] c, input logic [31:0] exp);
    int n;
    @(negedge clk);
    core_addr = a;
    core_ldst = c;
    core_we   = 1'b0;
    core_re   = 1'b1;
    #1;
    if (ref_bad(a, c)) begin
      check1("ld_misalign", core_misalign, 1'b1);
      check1("ld_bad_stall", core_stall, 1'b0);
      check("ld_bad_rdata", core_rdata, 32'h0);
      check("ld_bad_be", 32'(bram_be), 32'h0);
    end else begin
      check1("ld_no_misalign", core_misalign, 1'b0);
      check("ld_be", 32'(bram_be), 32'h0);
      n = 0;
      while (core_stall === 1'b1 && n < 10) begin
        n++;
        @(negedge clk);
        #1;
      end
      check("ld_stall_cycles", 32'(n), 32'(RD_LAT + 1));
      check("ld_data", core_rdata, exp);
      @(negedge clk);
      core_re = 1'b0;
      #1;
      check("ld_hold", core_rdata, exp);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    core_we = 1'b0;
    core_re = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, lw_exp;
    logic [2:0]  c;
    int          n;

    rst = 1'b1; mem_init = 1'b1;
    core_addr = '0; core_wdata = '0; core_we = 1'b0; core_re = 1'b0; core_ldst = 3'd2;
    uart_mode = 1'b0; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    #1;
    check1("rst_stall", core_stall, 1'b0);
    check1("rst_misalign", core_misalign, 1'b0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_be", 32'(bram_be), 32'h0);

    // Write-then-read with sub-word extension.
    do_store(32'h10, 32'hDEAD_BEEF, 3'b010);
    do_load(32'h13, 3'b100, 32'h0000_00DE);
    do_load(32'h13, 3'b000, 32'hFFFF_FFDE);
    do_load(32'h12, 3'b001, 32'hFFFF_DEAD);

    // Byte store into a zero word.
    do_store(32'h21, 32'h0000_007F, 3'b000);
    check("sb_be_literal", 32'(bram_be), 32'h2);
    check("sb_wdata_literal", bram_wdata, 32'h7F7F_7F7F);
    do_load(32'h20, 3'b010, 32'h0000_7F00);

    // Misaligned and illegal accesses.
    do_load(32'h6, 3'b010, 32'h0);
    do_load(32'h11, 3'b101, 32'h0);
    do_load(32'h10, 3'b011, 32'h0);
    do_store(32'h10, 32'h1234_5678, 3'b111);
    do_store(32'h22, 32'h1234_5678, 3'b010);
    go_idle();
    do_load(32'h10, 3'b010, 32'hDEAD_BEEF);

    // Loader takes over while a load is in flight.
    lw_exp = ref_load(32'h10, 3'b010);
    @(negedge clk);
    core_addr = 32'h10; core_ldst = 3'b010; core_re = 1'b1;
    #1;
    check1("ct_req_stall", core_stall, 1'b1);
    @(negedge clk);
    uart_mode = 1'b1;
    #1;
    check1("ct_wait_stall", core_stall, 1'b1);
    n = 0;
    while (core_stall === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    check1("ct_ld_done", n < 10, 1'b1);
    check("ct_ld_data", core_rdata, lw_exp);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      core_re = 1'b0; uart_we = 1'b1; uart_addr = AB'(k); uart_wdata = $urandom;
      #1;
      check("ct_uart_be", 32'(bram_be), 32'hF);
      check("ct_uart_addr", 32'(bram_addr), 32'(k));
      check("ct_uart_wdata", bram_wdata, uart_wdata);
      ref_mem[k] = uart_wdata;
    end
    d = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      uart_we = 1'b0; core_addr = 32'h40; core_wdata = d; core_ldst = 3'b010; core_we = 1'b1;
      #1;
      check1("ct_sw_stall", core_stall, 1'b1);
      check("ct_sw_be", 32'(bram_be), 32'h0);
    end
    @(negedge clk);
    uart_mode = 1'b0;
    #1;
    n = 0;
    while (core_stall === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    check1("ct_sw_release", n < 10, 1'b1);
    check("ct_sw_be_after", 32'(bram_be), 32'hF);
    ref_store(32'h40, d, 3'b010);
    go_idle();
    for (int k = 0; k < 3; k++) do_load(32'(4 * k), 3'b010, ref_mem[k]);
    do_load(32'h40, 3'b010, d);

    // Reset during RD_WAIT aborts cleanly.
    @(negedge clk);
    core_addr = 32'h44; core_ldst = 3'b010; core_re = 1'b1; core_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rd_be", 32'(bram_be), 32'h0);
    @(negedge clk);
    rst = 1'b0; core_re = 1'b0;
    #1;
    check1("rst_rd_stall", core_stall, 1'b0);
    check("rst_rd_be_after", 32'(bram_be), 32'h0);
    check("rst_rd_rdata", core_rdata, 32'h0);
    check1("rst_rd_misalign", core_misalign, 1'b0);
    do_load(32'h44, 3'b010, ref_load(32'h44, 3'b010));

    // Randomized traffic; upper address bits are noise that must wrap away.
    for (int i = 0; i < 80; i++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1:    c = 3'd0;
        2, 3:    c = 3'd1;
        4, 5:    c = 3'd2;
        6:       c = 3'd4;
        7:       c = 3'd5;
        default: c = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 1) == 1) do_store(a, d, c);
      else                           do_load(a, c, ref_load(a, c));
    end
    go_idle();
    for (int k = 0; k < 32; k++) do_load(32'(4 * k), 3'b010, ref_mem[k]);

    go_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
